// File: rtl/fpu_io_pkg.sv
// Shared definitions for the FPU result serializer, the collector and benches.
package fpu_io_pkg;

    localparam int FRAME_BYTES = 4;
    localparam int FP_W        = 32;

    // Collector frame-tracking states.
    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        COLLECT,
        DRAIN
    } frame_state_e;

endpackage

// File: rtl/result_frame_collector_if.sv
// Byte-stream input and word/flag output bundle of the result frame collector.
interface result_frame_collector_if
    import fpu_io_pkg::*;
#(
    parameter int WORD_W = FP_W
);
    logic [7:0]        byte_in;
    logic              stream_en;
    logic              frame_tgl;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic              frame_err;
    logic              overrun;
    logic              tgl_err;
    logic              clr_flags;

    // Collector side: consumes the stream, produces word and flags.
    modport master (
        input  byte_in, stream_en, frame_tgl, word_ready, clr_flags,
        output word_out, word_valid, frame_err, overrun, tgl_err
    );

    // Source/consumer side: drives the stream, takes word and flags.
    modport slave (
        output byte_in, stream_en, frame_tgl, word_ready, clr_flags,
        input  word_out, word_valid, frame_err, overrun, tgl_err
    );
endinterface

// File: rtl/frame_edge_detect.sv
// Registers stream_en and the frame_tgl value seen at the last frame start;
// produces the stream_en falling strobe and the "toggle changed" indication.
module frame_edge_detect
    import fpu_io_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic stream_en,
    input  logic frame_tgl,
    input  logic frame_start,
    output logic se_fall,
    output logic tgl_chg
);
    logic stream_en_q, stream_en_d;
    logic prev_tgl_q,  prev_tgl_d;

    // Next values: stream_en is delayed one sample; prev_tgl only moves at a frame start.
    always_comb begin
        stream_en_d = stream_en;
        prev_tgl_d  = prev_tgl_q;
        if (frame_start) begin
            prev_tgl_d = frame_tgl;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stream_en_q <= 1'b0;
            prev_tgl_q  <= 1'b0;
        end else begin
            stream_en_q <= stream_en_d;
            prev_tgl_q  <= prev_tgl_d;
        end
    end

    assign se_fall = stream_en_q & ~stream_en;
    assign tgl_chg = frame_tgl ^ prev_tgl_q;

endmodule

// File: rtl/result_frame_collector.sv
// Reassembles the serializer's LSB-first byte frames into words and hands
// them out over valid/ready, flagging truncated, dropped and untoggled frames.
module result_frame_collector
    import fpu_io_pkg::*;
#(
    parameter int WORD_BYTES = FRAME_BYTES,
    parameter int WORD_W     = 8 * WORD_BYTES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    result_frame_collector_if.master bus
);
    localparam int CNT_W = $clog2(WORD_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BYTES - 1);

    frame_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              tgl_err_q, tgl_err_d;
    logic              frame_start;
    logic              se_fall;
    logic              tgl_chg;

    frame_edge_detect u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .stream_en   (bus.stream_en),
        .frame_tgl   (bus.frame_tgl),
        .frame_start (frame_start),
        .se_fall     (se_fall),
        .tgl_chg     (tgl_chg)
    );

    // Next-state, assembly and flag logic; set events are applied after clears so they win.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        word_d      = word_q;
        valid_d     = valid_q;
        ferr_d      = 1'b0;
        ovr_d       = ovr_q;
        tgl_err_d   = tgl_err_q;
        frame_start = 1'b0;

        if (valid_q && bus.word_ready) begin
            valid_d = 1'b0;
        end
        if (bus.clr_flags) begin
            ovr_d     = 1'b0;
            tgl_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.stream_en) begin
                    state_d     = LEAD;
                    frame_start = 1'b1;
                    if (!tgl_chg) begin
                        tgl_err_d = 1'b1;
                    end
                end
            end
            LEAD: begin
                if (se_fall) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    asm_d[7:0] = bus.byte_in;
                    cnt_d      = CNT_W'(1);
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (se_fall) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            asm_d[8*i +: 8] = bus.byte_in;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                        // Slot is free if empty or being consumed on this same edge.
                        if (!valid_q || bus.word_ready) begin
                            word_d  = asm_d;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!bus.stream_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            asm_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            tgl_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            tgl_err_q <= tgl_err_d;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.tgl_err    = tgl_err_q;

endmodule

// File: tb/tb_result_frame_collector.sv
// Self-checking bench: frame-level stimulus against a transaction model.
module tb_result_frame_collector;
    import fpu_io_pkg::*;

    logic clk;
    logic rst_n;

    result_frame_collector_if #(.WORD_W(FP_W)) s ();

    result_frame_collector #(.WORD_BYTES(FRAME_BYTES), .WORD_W(FP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: expected visible outputs, updated per frame event.
    logic [FP_W-1:0] m_word;
    logic            m_valid;
    logic            m_ferr;
    logic            m_ovr;
    logic            m_tgl;
    logic            m_prev;
    bit              rnd_hs;

    task automatic chk(input string tag, input logic [FP_W-1:0] got, input logic [FP_W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("word_out",   s.word_out, m_word);
        chk("word_valid", FP_W'(s.word_valid), FP_W'(m_valid));
        chk("frame_err",  FP_W'(s.frame_err),  FP_W'(m_ferr));
        chk("overrun",    FP_W'(s.overrun),    FP_W'(m_ovr));
        chk("tgl_err",    FP_W'(s.tgl_err),    FP_W'(m_tgl));
    endtask

    task automatic model_reset();
        m_word  = '0;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        m_tgl   = 1'b0;
        m_prev  = 1'b0;
    endtask

    // One clock: apply inputs, let the edge happen, advance model, check.
    task automatic tick(input logic se, input logic [7:0] b, input bit start,
                        input bit last, input bit trunc, input logic [FP_W-1:0] w);
        if (rnd_hs) begin
            s.word_ready = ($urandom_range(0, 2) == 0);
            s.clr_flags  = ($urandom_range(0, 15) == 0);
        end
        s.stream_en = se;
        s.byte_in   = b;
        @(posedge clk);
        if (m_valid && s.word_ready) m_valid = 1'b0;
        if (s.clr_flags) begin
            m_ovr = 1'b0;
            m_tgl = 1'b0;
        end
        m_ferr = trunc;
        if (start) begin
            if (s.frame_tgl == m_prev) m_tgl = 1'b1;
            m_prev = s.frame_tgl;
        end
        if (last) begin
            if (!m_valid) begin
                m_word  = w;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, '0);
    endtask

    // nb < FRAME_BYTES sends a truncated frame of nb data bytes.
    task automatic send_frame(input logic [FP_W-1:0] w, input int nb, input bit tog,
                              input int drain, input bit rdy_last);
        bit lastb;
        if (tog) s.frame_tgl = ~s.frame_tgl;
        tick(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, w);
        for (int i = 0; i < nb; i++) begin
            lastb = (nb == FRAME_BYTES) && (i == FRAME_BYTES - 1);
            if (lastb && rdy_last) s.word_ready = 1'b1;
            tick(1'b1, w[8*i +: 8], 1'b0, lastb, 1'b0, w);
            if (lastb && rdy_last) s.word_ready = 1'b0;
        end
        if (nb < FRAME_BYTES) begin
            tick(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b1, w);
        end else begin
            for (int d = 0; d < drain; d++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, w);
            tick(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, w);
        end
        $display("frame w=%h bytes=%0d tog=%0d -> valid=%0d out=%h ovr=%0d tgl=%0d",
                 w, nb, tog, s.word_valid, s.word_out, s.overrun, s.tgl_err);
    endtask

    task automatic pulse_ready();
        s.word_ready = 1'b1;
        idle(1);
        s.word_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        s.clr_flags = 1'b1;
        idle(1);
        s.clr_flags = 1'b0;
    endtask

    initial begin
        rnd_hs      = 1'b0;
        rst_n       = 1'b0;
        s.byte_in   = '0;
        s.stream_en = 1'b0;
        s.frame_tgl = 1'b0;
        s.word_ready = 1'b0;
        s.clr_flags = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame 0x3F800000.
        idle(2);
        send_frame(32'h3F80_0000, 4, 1'b1, 0, 1'b0);
        chk("single_word", s.word_out, 32'h3F80_0000);
        pulse_ready();

        // Backpressure: second frame dropped, overrun sticky until cleared.
        send_frame(32'h4049_0FDB, 4, 1'b1, 1, 1'b0);
        send_frame(32'hC000_0000, 4, 1'b1, 0, 1'b0);
        chk("bp_word", s.word_out, 32'h4049_0FDB);
        chk("bp_ovr", FP_W'(s.overrun), FP_W'(1));
        pulse_ready();
        chk("bp_drained", FP_W'(s.word_valid), FP_W'(0));
        pulse_clr();
        chk("bp_clr", FP_W'(s.overrun), FP_W'(0));

        // Truncation after lead + 2 bytes, then a good frame.
        send_frame(32'h0000_BBAA, 2, 1'b1, 0, 1'b0);
        idle(1);
        send_frame(32'h1234_5678, 4, 1'b1, 0, 1'b0);
        chk("trunc_next", s.word_out, 32'h1234_5678);
        pulse_ready();

        // Truncated right after the lead cycle.
        send_frame(32'h0, 0, 1'b1, 0, 1'b0);

        // Back-to-back with consume on the completion edge.
        send_frame(32'h1122_3344, 4, 1'b1, 0, 1'b0);
        send_frame(32'h5566_7788, 4, 1'b1, 2, 1'b1);
        chk("b2b_word", s.word_out, 32'h5566_7788);
        chk("b2b_ovr", FP_W'(s.overrun), FP_W'(0));
        pulse_ready();

        // Toggle mismatch: second frame without a frame_tgl change.
        send_frame(32'hA5A5_0001, 4, 1'b1, 0, 1'b0);
        pulse_ready();
        send_frame(32'hA5A5_0002, 4, 1'b0, 0, 1'b0);
        chk("tgl_err", FP_W'(s.tgl_err), FP_W'(1));
        chk("tgl_word", s.word_out, 32'hA5A5_0002);
        pulse_ready();
        pulse_clr();

        // Async reset in the middle of COLLECT.
        s.frame_tgl = ~s.frame_tgl;
        tick(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, '0);
        #2;
        rst_n       = 1'b0;
        s.stream_en = 1'b0;
        s.frame_tgl = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(32'hDEAD_BEEF, 4, 1'b1, 0, 1'b0);
        chk("rst_frame", s.word_out, 32'hDEAD_BEEF);
        pulse_ready();

        // Randomized frames with random handshake and flag clearing.
        rnd_hs = 1'b1;
        for (int f = 0; f < 200; f++) begin
            send_frame($urandom,
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 4,
                       ($urandom_range(0, 7) != 0),
                       int'($urandom_range(0, 2)),
                       1'b0);
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
        end
        rnd_hs = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
